// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front-end: hold-FSM encoding and default timing.
// Auto-repeat hardware is only built when BTN_AUTOREPEAT_EN is defined.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPEAT = 2'd2
    } hold_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam int DEF_REPEAT_DELAY    = 20;
    localparam int DEF_REPEAT_RATE     = 5;
    localparam int DEF_CNT_W           = 16;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce, press/release edge pulses and optional hold FSM.
// The hold FSM and its counter exist only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
        maxOf3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE) > (1 << CNT_W)) begin : g_badCfg
        $error("btn_channel: timing parameters do not fit the counter width");
    end

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_dcnt;
    logic             w_rise;
    logic             w_fall;

    // r_level lags r_stable by one clock, so the edge pulses line up with the level change.
    assign w_rise = r_stable & ~r_level;
    assign w_fall = ~r_stable & r_level;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_stable  <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_dcnt    <= '0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_level   <= r_stable;
            r_press   <= w_rise;
            r_release <= w_fall;
            if (r_sync2 == r_stable) begin
                r_dcnt <= '0;
            end else if (r_dcnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_dcnt   <= '0;
            end else begin
                r_dcnt <= r_dcnt + CNT_W'(1);
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef BTN_AUTOREPEAT_EN
    hold_state_t      r_state;
    hold_state_t      w_nextState;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] w_nextHcnt;
    logic             r_repeat;
    logic             w_repeat;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_hcnt   <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_hcnt   <= w_nextHcnt;
            r_repeat <= w_repeat;
        end
    end

    // A debounced release always wins over a repeat terminal count in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextHcnt  = r_hcnt;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_nextState = WAIT;
                    w_nextHcnt  = '0;
                end
            end
            WAIT: begin
                if (w_fall) begin
                    w_nextState = IDLE;
                    w_nextHcnt  = '0;
                end else if (r_hcnt == CNT_W'(REPEAT_DELAY - 1)) begin
                    w_nextState = REPEAT;
                    w_nextHcnt  = '0;
                end else begin
                    w_nextHcnt = r_hcnt + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (w_fall) begin
                    w_nextState = IDLE;
                    w_nextHcnt  = '0;
                end else if (r_hcnt == CNT_W'(REPEAT_RATE - 1)) begin
                    w_nextHcnt = '0;
                end else begin
                    w_nextHcnt = r_hcnt + CNT_W'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextHcnt  = '0;
            end
        endcase
    end

    always_comb begin
        w_repeat = 1'b0;
        if (!w_fall) begin
            if (r_state == WAIT && r_hcnt == CNT_W'(REPEAT_DELAY - 1)) begin
                w_repeat = 1'b1;
            end else if (r_state == REPEAT && r_hcnt == CNT_W'(REPEAT_RATE - 1)) begin
                w_repeat = 1'b1;
            end
        end
    end

    assign o_repeat = r_repeat;
`else
    assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw push-buttons into clean levels and press/release/repeat pulses.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined; otherwise btn_repeat is 0.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_channel (
            .clock     (clock),
            .reset     (reset),
            .i_raw     (btn_raw[i]),
            .o_level   (btn_level[i]),
            .o_press   (btn_press[i]),
            .o_release (btn_release[i]),
            .o_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus queues expected pulses and quiet-state probes,
// a negedge monitor pops and compares them. Repeat expectations depend on BTN_AUTOREPEAT_EN.
module tb_btn_conditioner;

    typedef struct {
        int         cycle;
        logic [2:0] level;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] rep;
    } obs_t;

    // Raw change driven at a negedge shows up on the outputs 2 + 8 edges after the next posedge.
    localparam int LAT = 11;

    logic       clock;
    logic       reset;
    logic [2:0] btnRaw;
    logic [2:0] btnLevel;
    logic [2:0] btnPress;
    logic [2:0] btnRelease;
    logic [2:0] btnRepeat;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    logic done   = 1'b0;
    obs_t expQ[$];
    obs_t probeQ[$];
    obs_t e;

    btn_conditioner dut (
        .clock       (clock),
        .reset       (reset),
        .btn_raw     (btnRaw),
        .btn_level   (btnLevel),
        .btn_press   (btnPress),
        .btn_release (btnRelease),
        .btn_repeat  (btnRepeat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input obs_t exp);
        checks++;
        if (cyc != exp.cycle || btnLevel !== exp.level || btnPress !== exp.press ||
            btnRelease !== exp.rel || btnRepeat !== exp.rep) begin
            errors++;
            $display("[TB] FAIL %s: got cyc=%0d lvl=%b prs=%b rel=%b rep=%b, want cyc=%0d lvl=%b prs=%b rel=%b rep=%b",
                     name, cyc, btnLevel, btnPress, btnRelease, btnRepeat,
                     exp.cycle, exp.level, exp.press, exp.rel, exp.rep);
        end
    endtask

    // Monitor: probes fire on their cycle, pulse events fire whenever any pulse output is high.
    always @(negedge clock) begin
        if (probeQ.size() > 0 && probeQ[0].cycle <= cyc) begin
            e = probeQ.pop_front();
            checkOutput("probe", e);
        end
        if ((btnPress | btnRelease | btnRepeat) != 3'b000) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got cyc=%0d prs=%b rel=%b rep=%b, want no pulse",
                         cyc, btnPress, btnRelease, btnRepeat);
            end else begin
                e = expQ.pop_front();
                checkOutput("pulse", e);
            end
        end
        if (done) begin
            checks++;
            if (expQ.size() != 0 || probeQ.size() != 0) begin
                errors++;
                $display("[TB] FAIL leftover_expectations: got %0d pulses + %0d probes pending, want 0",
                         expQ.size(), probeQ.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [2:0] raw);
        btnRaw = raw;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic void expectPulse(input int c, input logic [2:0] lvl, input logic [2:0] prs,
                                        input logic [2:0] rel, input logic [2:0] rep);
        obs_t o;
        o.cycle = c; o.level = lvl; o.press = prs; o.rel = rel; o.rep = rep;
        expQ.push_back(o);
    endfunction

    function automatic void expectQuiet(input int c, input logic [2:0] lvl);
        obs_t o;
        o.cycle = c; o.level = lvl; o.press = 3'b000; o.rel = 3'b000; o.rep = 3'b000;
        probeQ.push_back(o);
    endfunction

    initial begin
        int now;
        int t;
        $display("[TB] btn_conditioner scoreboard bench starting");
        reset = 1'b0;
        btnRaw = 3'b111;
        @(negedge clock);

        // Reset held with all buttons pressed: everything stays 0, then one fresh press.
        expectQuiet(cyc + 2, 3'b000);
        expectQuiet(cyc + 6, 3'b000);
        expectQuiet(cyc + 9, 3'b000);
        waitCycles(10);
        reset = 1'b1;
        now = cyc;
        expectQuiet(now + 10, 3'b000);
        expectPulse(now + LAT, 3'b111, 3'b111, 3'b000, 3'b000);
        waitCycles(15);
        applyStimulus(3'b000);
        expectPulse(cyc + LAT, 3'b000, 3'b000, 3'b111, 3'b000);
        waitCycles(15);

        // Bounce on b1 for 12 clocks, then held high.
        for (int i = 0; i < 12; i++) begin
            btnRaw[0] = ~btnRaw[0];
            waitCycles(1);
        end
        btnRaw[0] = 1'b1;
        now = cyc;
        expectQuiet(now + 10, 3'b000);
        expectPulse(now + LAT, 3'b001, 3'b001, 3'b000, 3'b000);
        expectQuiet(now + 15, 3'b001);
        waitCycles(11);
        btnRaw[0] = 1'b0;
        expectPulse(cyc + LAT, 3'b000, 3'b000, 3'b001, 3'b000);
        waitCycles(15);

        // Seven-clock glitch on b2 is one short of acceptance.
        now = cyc;
        btnRaw[1] = 1'b1;
        waitCycles(7);
        btnRaw[1] = 1'b0;
        expectQuiet(now + 11, 3'b000);
        expectQuiet(now + 13, 3'b000);
        expectQuiet(now + 20, 3'b000);
        waitCycles(22);

        // Clean b3 press and release.
        btnRaw[2] = 1'b1;
        expectPulse(cyc + LAT, 3'b100, 3'b100, 3'b000, 3'b000);
        waitCycles(11);
        btnRaw[2] = 1'b0;
        expectQuiet(cyc + 10, 3'b100);
        expectPulse(cyc + LAT, 3'b000, 3'b000, 3'b100, 3'b000);
        waitCycles(15);

        // Long b1 hold; release lands on what would have been the fifth repeat.
        btnRaw[0] = 1'b1;
        t = cyc + LAT;
        expectPulse(t, 3'b001, 3'b001, 3'b000, 3'b000);
`ifdef BTN_AUTOREPEAT_EN
        expectPulse(t + 20, 3'b001, 3'b000, 3'b000, 3'b001);
        expectPulse(t + 25, 3'b001, 3'b000, 3'b000, 3'b001);
        expectPulse(t + 30, 3'b001, 3'b000, 3'b000, 3'b001);
        expectPulse(t + 35, 3'b001, 3'b000, 3'b000, 3'b001);
`endif
        waitCycles(40);
        btnRaw[0] = 1'b0;
        expectPulse(t + 40, 3'b000, 3'b000, 3'b001, 3'b000);
        expectQuiet(t + 45, 3'b000);
        waitCycles(20);

        // b1 and b3 together while b2 bounces.
        now = cyc;
        applyStimulus(3'b111);
        waitCycles(1); btnRaw[1] = 1'b0;
        waitCycles(1); btnRaw[1] = 1'b1;
        waitCycles(1); btnRaw[1] = 1'b0;
        waitCycles(1); btnRaw[1] = 1'b1;
        expectPulse(now + 11, 3'b101, 3'b101, 3'b000, 3'b000);
        expectQuiet(now + 12, 3'b101);
        expectPulse(now + 15, 3'b111, 3'b010, 3'b000, 3'b000);
        waitCycles(11);
        applyStimulus(3'b000);
        expectPulse(cyc + LAT, 3'b000, 3'b000, 3'b111, 3'b000);
        waitCycles(15);

        // Reset in the middle of a b1 hold, button still held at reset release.
        applyStimulus(3'b001);
        expectPulse(cyc + LAT, 3'b001, 3'b001, 3'b000, 3'b000);
        waitCycles(16);
        reset = 1'b0;
        expectQuiet(cyc + 1, 3'b000);
        expectQuiet(cyc + 3, 3'b000);
        waitCycles(5);
        reset = 1'b1;
        expectPulse(cyc + LAT, 3'b001, 3'b001, 3'b000, 3'b000);
        waitCycles(11);
        applyStimulus(3'b000);
        expectPulse(cyc + LAT, 3'b000, 3'b000, 3'b001, 3'b000);
        waitCycles(20);

        done = 1'b1;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end for the three user push-buttons (b1..b3) of the clock/display top level.
- Synchronises, debounces and edge-detects each raw button.
- Delivers clean levels plus single-cycle press/release (and optional auto-repeat) pulses to the time-setting/mode logic.
- Sits between the board pins and the clock-core state machine; one instance serves all buttons.

Parameters:
- N_BTN, 3, number of button channels.
- DEBOUNCE_CYCLES, 8, consecutive stable clocks required to accept a new level (≥2).
- CNT_W, 16, width of the debounce and hold counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).
- REPEAT_DELAY, 20, clocks a button must stay pressed before the first repeat pulse.
- REPEAT_RATE, 5, clocks between subsequent repeat pulses.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_raw  in  N_BTN  raw asynchronous button inputs, 1 = pressed.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-clock pulse on debounced 0->1.
- btn_release  out  N_BTN  one-clock pulse on debounced 1->0.
- btn_repeat  out  N_BTN  one-clock auto-repeat pulse while held.

Behaviour:
- Reset (reset=0, asynchronous) clears all state:
  - synchroniser flops, stable level, counters and all outputs go to 0.
  - Outputs stay 0 until the first accepted press after reset release.
- Per channel, fully independent:
  - Synchroniser: 2-flop chain s1->s2 on btn_raw[i].
  - Debounce counter dcnt:
    - if s2 == stable: dcnt <= 0.
    - else if dcnt == DEBOUNCE_CYCLES-1: stable <= s2, dcnt <= 0.
    - else dcnt <= dcnt+1.
  - Net effect: stable changes on the DEBOUNCE_CYCLES-th consecutive clock edge at which s2 differs from stable.
  - Any glitch back to the stable value restarts the count from 0.
- Latency: a clean raw edge is reflected in btn_level exactly 2 + DEBOUNCE_CYCLES clock edges after the first edge that samples it.
- Edge pulses:
  - btn_press[i] is registered and high for exactly the one cycle in which btn_level[i] first reads 1.
  - btn_release[i] behaves the same way for 0.
  - press and release are never high together.
- Hold FSM per channel, states IDLE, WAIT, REPEAT:
  - IDLE: on stable 0->1 go to WAIT, hcnt <= 0.
  - WAIT: hcnt increments each clock. When hcnt == REPEAT_DELAY-1, pulse btn_repeat, go to REPEAT, hcnt <= 0.
  - REPEAT: hcnt increments each clock. When hcnt == REPEAT_RATE-1, pulse btn_repeat, hcnt <= 0.
  - From WAIT or REPEAT: debounced release (stable 1->0) returns to IDLE immediately, with no repeat pulse that cycle. Release takes priority over a coinciding repeat terminal count.
- Counters never wrap; each is cleared at its terminal value.
- Reset asserted mid-press returns every channel to IDLE with all outputs 0. A button still held at reset release produces a fresh btn_press after 2 + DEBOUNCE_CYCLES clocks.
- Simultaneous presses on multiple channels produce simultaneous pulses; there is no priority or arbitration.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: the hold FSM and hold counters are built, and btn_repeat behaves as above.
- Undefined: the hold FSM and hold counters are not synthesised, and btn_repeat is tied to 0. All other outputs are unchanged.

Decomposition:
- Shared package btn_pkg holds:
  - hold-FSM state encoding: IDLE=2'd0, WAIT=2'd1, REPEAT=2'd2.
  - default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE.
- Natural sub-module btn_channel: one synchroniser + debounce + edge + hold FSM for one button.
- btn_conditioner is a generate loop of N_BTN btn_channel instances.

Test Plan (defaults DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_RATE=5):
- Reset check: hold reset low 10 clocks with btn_raw=3'b111 -> all outputs 0. After release, btn_press=3'b111 pulses once, 10 clocks later.
- Bounce rejection: b1 toggles every 1 clock for 12 clocks, then held high -> no pulse during bouncing. One btn_press[0] pulse 10 clocks after the last toggle; btn_level[0]=1 thereafter.
- Short glitch: b2 high for 7 clocks, then low -> btn_level[1] stays 0, no press or release.
- Release: after a clean b3 press, drop b3 low -> exactly one btn_release[2] pulse 10 clocks after the falling edge, with btn_press[2]=0 in that cycle.
- Auto-repeat (macro defined): hold b1 for 40 clocks after btn_press[0]:
  - first btn_repeat[0] on the 20th clock after the press;
  - further repeats every 5 clocks (4 repeats in total);
  - releasing stops the repeats; with the macro undefined, btn_repeat stays 0.
- Independence: press b1 and b3 on the same clock while b2 bounces -> btn_press[0] and btn_press[2] are coincident, and b2 is unaffected until it has been stable for 8 clocks.
